fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port valid_i, input, 1 bit, meaning fetch presents an instruction.
REQ-005 SHALL have port pc_i, input, 32 bits (bus32_t), meaning the PC of the presented instruction.
REQ-006 SHALL have port instr_i, input, 32 bits (instruction_t), meaning the presented instruction word.
REQ-007 SHALL have port flush_i, input, 1 bit, meaning a taken branch has redirected fetch.
REQ-008 SHALL have port stall_o, output, 1 bit, meaning queue full; drives the fetch stall input.
REQ-009 SHALL have port ready_i, input, 1 bit, meaning decode accepts the head entry this cycle.
REQ-010 SHALL have port valid_o, output, 1 bit, meaning pc_o/instr_o hold a valid entry for decode.
REQ-011 SHALL have port pc_o, output, 32 bits, meaning the PC of the head entry.
REQ-012 SHALL have port instr_o, output, 32 bits, meaning the instruction of the head entry.

Function
REQ-013 SHALL be a circular FIFO with head and tail pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0, plus an occupancy count of clog2(DEPTH+1) bits.
REQ-014 SHALL push {pc_i, instr_i} at the tail on a rising edge when valid_i=1, stall_o=0 and flush_i=0.
REQ-015 SHALL pop the head entry on a rising edge when valid_o=1, ready_i=1 and flush_i=0.
REQ-016 SHALL perform a simultaneous push and pop in the same cycle, leaving the count unchanged.
REQ-017 SHALL drive stall_o=1 exactly when the registered count equals DEPTH; no push while full, even if a pop occurs that cycle.
REQ-018 SHALL drive valid_o=1 exactly when the count is nonzero (except the bypass case, REQ-025).
REQ-019 SHALL drive pc_o and instr_o to 32'h0 whenever valid_o=0.
REQ-020 SHALL, on flush_i=1, set count, head and tail to 0 at the next edge, discarding all entries and any input presented that cycle; valid_o=0 and stall_o=0 in the following cycle.
REQ-021 SHALL give flush_i priority over any simultaneous push or pop.
REQ-022 SHALL preserve entry order; decode sees PCs in fetch order between flushes.
REQ-023 SHALL not change the head entry outputs while valid_o=1 and ready_i=0.

Reset
REQ-024 SHALL, while rstn_i=0, clear count, head and tail to 0, giving valid_o=0, stall_o=0, pc_o=32'h0 and instr_o=32'h0, regardless of clk_i.

Configuration
REQ-025 SHALL, with FETCH_QUEUE_BYPASS_EN defined, pass through combinationally when count=0, valid_i=1 and flush_i=0: valid_o=1, pc_o=pc_i, instr_o=instr_i. If ready_i=1 the entry is consumed and not written; if ready_i=0 it is pushed normally.
REQ-026 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from pc_i, instr_i, valid_i, or ready_i to any output; minimum push-to-valid_o latency is one cycle.

Verification
REQ-027 Reset: hold rstn_i=0 with valid_i=1 and pc_i=32'h80000000 -> valid_o=0, stall_o=0, pc_o=0, instr_o=0; after release, first push appears one cycle later (no bypass).
REQ-028 Fill: ready_i=0, push PCs 0x80000000..0x8000000C (DEPTH=4) -> stall_o=1 after the fourth edge; a fifth input is not stored; draining yields the four PCs in order.
REQ-029 Full with pop: full queue, ready_i=1, valid_i=1 -> pop only, count 3, stall_o=0 next cycle; the next push is accepted.
REQ-030 Flush: three entries queued, flush_i=1 together with valid_i=1 and ready_i=1 -> next cycle valid_o=0, count 0; the next push of 0x80000100 is the first PC out.
REQ-031 Wrap: stream 10 instructions with ready_i toggling each cycle -> all 10 PCs out in order, with no loss or duplication across pointer wrap.
REQ-032 Bypass (macro defined): empty queue, valid_i=1, ready_i=1, pc_i=0x80000040 -> valid_o=1, pc_o=0x80000040 in the same cycle, and count remains 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between fetch and decode, with flush and full-stall.
// Optional combinational pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        flush_i,
    output logic        stall_o,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic full, empty, bypass, push, pop;
    logic [63:0] head_entry;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_entry = mem_q[head_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle never occupies a slot.
    assign push = valid_i & ~full & ~flush_i & ~(bypass & ready_i);
    assign pop  = ~empty & ready_i & ~flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = next_ptr(tail_q);
            if (pop)  head_d = next_ptr(head_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= {pc_i, instr_i};
    end

    always_comb begin
        stall_o = full;
        valid_o = ~empty | bypass;
        pc_o    = '0;
        instr_o = '0;
        if (bypass) begin
            pc_o    = pc_i;
            instr_o = instr_i;
        end else if (!empty) begin
            pc_o    = head_entry[63:32];
            instr_o = head_entry[31:0];
        end
    end

endmodule
